// File: rtl/risc16_pkg.sv
// risc16_pkg: shared loader state encoding and byte-lane write-enable constants
package risc16_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} ld_state_t;
    localparam logic [1:0] WE_HI   = 2'b01;
    localparam logic [1:0] WE_LO   = 2'b10;
    localparam logic [1:0] WE_WORD = 2'b11;
endpackage

// File: rtl/mem2p_be.sv
// mem2p_be: 16-bit word store, one sync byte-enabled write port, two async read ports
// ports: clk; we[1:0] (bit0 -> [15:8], bit1 -> [7:0]), waddr, wdata; ra/rd_a, rb/rd_b reads
module mem2p_be
    import risc16_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [1:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] ra,
    output logic [15:0]   rd_a,
    input  logic [AW-1:0] rb,
    output logic [15:0]   rd_b
);
    logic [15:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if ((we & WE_HI) != 2'b00) mem[waddr][15:8] <= wdata[15:8];
        if ((we & WE_LO) != 2'b00) mem[waddr][7:0] <= wdata[7:0];
    end
    assign rd_a = mem[ra];
    assign rd_b = mem[rb];
endmodule

// File: rtl/risc16_mem_responder.sv
// risc16_mem_responder: unified instruction/data memory with a host word loader holding the core in reset
// ports: clk, rst (sync, active-high); i_addr/i_oe/i_dout instruction read; d_addr/d_oe/d_rdata/d_wdata/d_we data port;
//        ld_start/ld_valid/ld_ready/ld_data/ld_last loader stream; cpu_rst core reset; ld_count, ld_overflow loader status
module risc16_mem_responder
    import risc16_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   i_addr,
    input  logic          i_oe,
    output logic [15:0]   i_dout,
    input  logic [15:0]   d_addr,
    input  logic          d_oe,
    output logic [15:0]   d_rdata,
    input  logic [15:0]   d_wdata,
    input  logic [1:0]    d_we,
    input  logic          ld_start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [15:0]   ld_data,
    input  logic          ld_last,
    output logic          cpu_rst,
    output logic [AW:0]   ld_count,
    output logic          ld_overflow
);
    ld_state_t     state;
    logic [AW-1:0] ptr;
    logic          accept;
    logic [1:0]    we;
    logic [AW-1:0] waddr;
    logic [15:0]   wdata, rd_i, rd_d;
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[15:AW+1], i_addr[0], d_addr[15:AW+1], d_addr[0]};
    // loader and CPU writes live in disjoint states, so one shared write port suffices
    always_comb begin
        accept   = state == LOAD && ld_valid && !rst;
        we       = accept ? WE_WORD : (state == RUN && !rst ? d_we : 2'b00);
        waddr    = accept ? ptr : d_addr[AW:1];
        wdata    = accept ? ld_data : d_wdata;
        cpu_rst  = state != RUN;
        ld_ready = state == LOAD;
        i_dout   = i_oe ? rd_i : 16'h0000;
        d_rdata  = d_oe ? rd_d : 16'h0000;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            ld_count    <= '0;
            ld_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: if (ld_start) begin
                    state       <= LOAD;
                    ptr         <= '0;
                    ld_count    <= '0;
                    ld_overflow <= 1'b0;
                end
                LOAD: if (ld_valid) begin
                    ptr      <= ptr + 1'b1;
                    ld_count <= ld_count + 1'b1;
                    if (ld_last) state <= RUN;
                    else if (&ptr) begin
                        // last word filled without ld_last: stop accepting and release the core
                        ld_overflow <= 1'b1;
                        state       <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    mem2p_be #(.AW(AW)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .ra    (i_addr[AW:1]),
        .rd_a  (rd_i),
        .rb    (d_addr[AW:1]),
        .rd_b  (rd_d)
    );
endmodule

// File: tb/tb_risc16_mem_responder.sv
// tb_risc16_mem_responder: directed tests of loader, byte-lane writes, overflow, state gating, reset and wrap
module tb_risc16_mem_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0, ld_data = '0;
    logic        i_oe = 1'b0, d_oe = 1'b0, ld_start = 1'b0, ld_start4 = 1'b0, ld_valid = 1'b0, ld_last = 1'b0;
    logic [1:0]  d_we = 2'b00;
    logic [15:0] i_dout, d_rdata, i_dout4, d_rdata4;
    logic        ld_ready, cpu_rst, ld_overflow, ld_ready4, cpu_rst4, ld_overflow4;
    logic [12:0] ld_count;
    logic [4:0]  ld_count4;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    risc16_mem_responder #(.AW(12)) dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_oe(i_oe), .i_dout(i_dout),
        .d_addr(d_addr), .d_oe(d_oe), .d_rdata(d_rdata), .d_wdata(d_wdata), .d_we(d_we),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .cpu_rst(cpu_rst), .ld_count(ld_count), .ld_overflow(ld_overflow)
    );

    risc16_mem_responder #(.AW(4)) dut4 (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_oe(i_oe), .i_dout(i_dout4),
        .d_addr(d_addr), .d_oe(d_oe), .d_rdata(d_rdata4), .d_wdata(d_wdata), .d_we(d_we),
        .ld_start(ld_start4), .ld_valid(ld_valid), .ld_ready(ld_ready4), .ld_data(ld_data), .ld_last(ld_last),
        .cpu_rst(cpu_rst4), .ld_count(ld_count4), .ld_overflow(ld_overflow4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        #1;
        n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_rst got %b want 1", cpu_rst); end
        n_cmp++; if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ld_ready got %b want 0", ld_ready); end
        n_cmp++; if (ld_count !== 13'd0) begin n_bad++; $display("FAIL reset_ld_count got %0d want 0", ld_count); end
        n_cmp++; if (ld_overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ld_overflow got %b want 0", ld_overflow); end
        n_cmp++; if (i_dout !== 16'h0 || d_rdata !== 16'h0) begin n_bad++; $display("FAIL reset_reads got %h/%h want 0000/0000", i_dout, d_rdata); end
        rst = 1'b0;
    endtask

    task automatic test_load;
        logic [15:0] words [3];
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333;
        tick();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = words[i]; ld_last = (i == 2);
            #1;
            n_cmp++; if (ld_ready !== 1'b1 || cpu_rst !== 1'b1) begin n_bad++; $display("FAIL load_hs%0d got ready=%b cpu_rst=%b want 1/1", i, ld_ready, cpu_rst); end
            tick();
        end
        ld_valid = 1'b0; ld_last = 1'b0;
        i_addr = 16'h0004; i_oe = 1'b1;
        #1;
        n_cmp++; if (cpu_rst !== 1'b0) begin n_bad++; $display("FAIL load_cpu_rst got %b want 0", cpu_rst); end
        n_cmp++; if (ld_count !== 13'd3) begin n_bad++; $display("FAIL load_count got %0d want 3", ld_count); end
        n_cmp++; if (i_dout !== 16'h3333) begin n_bad++; $display("FAIL load_word2 got %h want 3333", i_dout); end
        i_addr = 16'h0000;
        #1;
        n_cmp++; if (i_dout !== 16'h1111) begin n_bad++; $display("FAIL load_word0 got %h want 1111", i_dout); end
        i_oe = 1'b0;
    endtask

    task automatic test_byte_lanes;
        d_addr = 16'h000A; d_oe = 1'b1; d_we = 2'b11; d_wdata = 16'hABCD;
        tick();
        d_we = 2'b01; d_wdata = 16'h5500;
        #1;
        n_cmp++; if (d_rdata !== 16'hABCD) begin n_bad++; $display("FAIL lane_prewrite got %h want abcd", d_rdata); end
        tick();
        d_we = 2'b10; d_wdata = 16'h0066;
        #1;
        n_cmp++; if (d_rdata !== 16'h55CD) begin n_bad++; $display("FAIL lane_hi got %h want 55cd", d_rdata); end
        tick();
        d_we = 2'b00;
        #1;
        n_cmp++; if (d_rdata !== 16'h5566) begin n_bad++; $display("FAIL lane_lo got %h want 5566", d_rdata); end
        d_addr = 16'h0020; d_we = 2'b11; d_wdata = 16'h1234;
        tick();
        d_we = 2'b00; d_oe = 1'b0;
        #1;
        n_cmp++; if (d_rdata !== 16'h0000) begin n_bad++; $display("FAIL lane_oe_low got %h want 0000", d_rdata); end
    endtask

    task automatic test_overflow;
        ld_start4 = 1'b1;
        tick();
        ld_start4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ld_valid = 1'b1; ld_data = 16'h0100 + 16'(i);
            tick();
        end
        ld_data = 16'h0110;
        #1;
        n_cmp++; if (ld_ready4 !== 1'b0) begin n_bad++; $display("FAIL ovf_ready got %b want 0", ld_ready4); end
        n_cmp++; if (ld_overflow4 !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", ld_overflow4); end
        n_cmp++; if (cpu_rst4 !== 1'b0) begin n_bad++; $display("FAIL ovf_run got cpu_rst=%b want 0", cpu_rst4); end
        tick();
        ld_valid = 1'b0;
        i_oe = 1'b1; i_addr = 16'h0000;
        #1;
        n_cmp++; if (ld_count4 !== 5'd16) begin n_bad++; $display("FAIL ovf_count got %0d want 16", ld_count4); end
        n_cmp++; if (i_dout4 !== 16'h0100) begin n_bad++; $display("FAIL ovf_word0 got %h want 0100", i_dout4); end
        i_addr = 16'h001E;
        #1;
        n_cmp++; if (i_dout4 !== 16'h010F) begin n_bad++; $display("FAIL ovf_word15 got %h want 010f", i_dout4); end
        i_oe = 1'b0;
    endtask

    task automatic test_gating_and_rst;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        d_addr = 16'h0020; d_we = 2'b11; d_wdata = 16'hDEAD;
        tick();
        d_we = 2'b00; ld_valid = 1'b1; ld_data = 16'hBAD0;
        tick();
        ld_valid = 1'b0; d_oe = 1'b1;
        #1;
        n_cmp++; if (d_rdata !== 16'h1234) begin n_bad++; $display("FAIL idle_write got %h want 1234", d_rdata); end
        n_cmp++; if (ld_count !== 13'd0) begin n_bad++; $display("FAIL idle_valid got count=%0d want 0", ld_count); end
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0; d_we = 2'b11; d_wdata = 16'hDEAD;
        tick();
        d_we = 2'b00;
        #1;
        n_cmp++; if (d_rdata !== 16'h1234) begin n_bad++; $display("FAIL load_write got %h want 1234", d_rdata); end
        ld_valid = 1'b1; ld_data = 16'hAAAA;
        tick();
        ld_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; i_addr = 16'h0000; i_oe = 1'b1;
        #1;
        n_cmp++; if (cpu_rst !== 1'b1 || ld_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_state got cpu_rst=%b ready=%b want 1/0", cpu_rst, ld_ready); end
        n_cmp++; if (ld_count !== 13'd0) begin n_bad++; $display("FAIL midrst_count got %0d want 0", ld_count); end
        n_cmp++; if (i_dout !== 16'hAAAA) begin n_bad++; $display("FAIL midrst_mem got %h want aaaa", i_dout); end
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'h7777; ld_last = 1'b1;
        tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        #1;
        n_cmp++; if (i_dout !== 16'h7777) begin n_bad++; $display("FAIL reload_mem got %h want 7777", i_dout); end
        n_cmp++; if (ld_count !== 13'd1 || cpu_rst !== 1'b0) begin n_bad++; $display("FAIL reload_state got count=%0d cpu_rst=%b want 1/0", ld_count, cpu_rst); end
        i_oe = 1'b0; d_oe = 1'b0;
    endtask

    task automatic test_wrap;
        d_addr = 16'h2002; d_we = 2'b11; d_wdata = 16'hBEEF;
        tick();
        d_we = 2'b00; i_addr = 16'h0002; i_oe = 1'b1; d_addr = 16'h0003; d_oe = 1'b1;
        #1;
        n_cmp++; if (i_dout !== 16'hBEEF) begin n_bad++; $display("FAIL wrap_iread got %h want beef", i_dout); end
        n_cmp++; if (d_rdata !== 16'hBEEF) begin n_bad++; $display("FAIL wrap_dread_odd got %h want beef", d_rdata); end
        i_oe = 1'b0;
        #1;
        n_cmp++; if (i_dout !== 16'h0000) begin n_bad++; $display("FAIL wrap_oe_low got %h want 0000", i_dout); end
        d_oe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_byte_lanes();
        test_overflow();
        test_gating_and_rst();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/risc16_mem_responder.md
Name: risc16_mem_responder

Overview:
- Memory-side responder for the risc16b core's instruction bus and data bus.
- Holds a unified word-organised program/data store that both buses access.
- Includes a host loader, a valid/ready word stream that fills memory from word 0 while the core is held in reset, then releases it.
- Sits between the core and the testbench/host. Core output ports connect to same-named inputs here: i_dout feeds the core's i_din, d_rdata feeds d_din, d_wdata is driven from the core's d_dout.

Parameters:
AW, 12, word-address width; depth = 2**AW 16-bit words (8 KiB).

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high. Clock is clk.
i_addr  input  16  instruction byte address; bit 0 ignored
i_oe  input  1  instruction read enable
i_dout  output  16  instruction word
d_addr  input  16  data byte address
d_oe  input  1  data read enable
d_rdata  output  16  data read word
d_wdata  input  16  data write word
d_we  input  2  byte write enables; bit0 selects [15:8] (even byte), bit1 selects [7:0] (odd byte)
ld_start  input  1  begin a load session
ld_valid  input  1  loader word valid
ld_ready  output  1  loader can accept a word
ld_data  input  16  loader word
ld_last  input  1  marks the final loader word
cpu_rst  output  1  reset to the core
ld_count  output  AW+1  number of words accepted in the current or last session
ld_overflow  output  1  sticky flag: loader wrote past the last word

Behaviour:
- Word index = addr[AW:1]. Upper address bits are ignored, so accesses wrap modulo depth. No error is raised on wrap.
- Reads are combinational:
  - i_dout = i_oe ? mem[i_addr idx] : 0.
  - d_rdata = d_oe ? mem[d_addr idx] : 0.
  - Same-cycle read and write to one word returns the old contents; the new value is visible the next cycle.
- CPU writes take effect on posedge, only in RUN:
  - d_we=11 writes the full word.
  - d_we=01 writes only [15:8] from d_wdata[15:8].
  - d_we=10 writes only [7:0] from d_wdata[7:0].
  - d_we=00 writes nothing.
  - d_addr[0] does not alter lane selection; the core has already steered the data.
- Memory contents are not cleared by rst.
- FSM states are IDLE, LOAD, RUN. Reset state is IDLE.
- IDLE:
  - cpu_rst=1, ld_ready=0.
  - CPU writes are dropped.
  - ld_start → LOAD next cycle; ptr and ld_count clear to 0 and ld_overflow clears.
- LOAD:
  - cpu_rst=1, ld_ready=1.
  - On ld_valid&ld_ready: mem[ptr]<=ld_data (all lanes), ptr++, ld_count++.
  - If the accepted word has ld_last=1 → RUN.
  - If the accepted word is at ptr=depth-1 and ld_last=0: set ld_overflow, go to RUN. Any remaining stream words are not accepted.
  - ld_start during LOAD is ignored.
  - CPU writes are dropped.
- RUN:
  - cpu_rst=0 starting the cycle after entry (cpu_rst decodes the registered state).
  - ld_ready=0.
  - ld_start → LOAD next cycle: cpu_rst reasserts, counters clear, memory keeps its old contents beyond the newly loaded words.
- A ld_valid without ld_start is never accepted. ld_last outside LOAD is ignored.
- rst during LOAD: return to IDLE, ld_count=0, ld_overflow=0. Words already written remain in memory.
- A loader write and a CPU write cannot coincide, because they are gated by disjoint states.
- Reset values: cpu_rst=1, ld_ready=0, ld_count=0, ld_overflow=0. i_dout and d_rdata are 0 while their enables are low.
- Latency:
  - Reads: 0 cycles.
  - Writes: visible the next cycle.
  - Loader: 1 word/cycle at full throughput.

Decomposition:
- Shared package risc16_pkg:
  - ld_state_t enum {IDLE, LOAD, RUN}.
  - Lane constants WE_HI=2'b01, WE_LO=2'b10, WE_WORD=2'b11.
- Sub-module mem2p_be, the storage array:
  - one synchronous write port with 2-bit byte enables;
  - two asynchronous read ports.
- The top module owns the FSM, ptr/ld_count, and the write mux (loader vs CPU).

Test Plan:
- rst; ld_start; stream 0x1111, 0x2222, 0x3333 with last on the third word → ld_count=3, cpu_rst falls 1 cycle after the third accept, i_addr=0x0004 with i_oe=1 gives i_dout=0x3333.
- RUN, mem[5]=0xABCD; d_addr=0x000A, d_we=01, d_wdata=0x5500 → read returns 0x55CD; then d_we=10, d_wdata=0x0066 → 0x5566; a same-cycle read during the write returns the pre-write value.
- AW=4: stream 17 words with no last → 16 accepted, ld_overflow=1, state RUN, ld_ready=0 while the 17th word is still valid.
- Drive d_we=11 while in IDLE/LOAD at address 0x0020 → mem unchanged; ld_valid pulses in IDLE → ld_count stays 0.
- Assert rst midway through a 3-word load after word 1 → IDLE, cpu_rst=1, ld_count=0, mem[0] keeps word 1; a new session overwrites it.
- Wrap: d_addr=0x2002 with AW=12 writes mem[1]; i_addr=0x0002 reads the same value; i_oe=0 → i_dout=0.
